clk_div_multi: RTL and testbench



---
 rtl/clk_div_multi.sv | 192 +++++++++++++++++++
 tb/tb_clk_div_multi.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel phase-accumulator clock divider with lock-filtered, staggered reset release.
// Define CLK_DIV_LOCK_LOSS_CNT_EN to add the saturating lock-loss counter (lock_loss_cnt_o, lock_loss_clr_i).

module clk_div_multi #(
  parameter int NCH         = 2,
  parameter int ACC_W       = 24,
  parameter int INC_RST     = 0,
  parameter int LOCK_FILT   = 16,
  parameter int RST_STAGGER = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked_i,
  input  logic [NCH*ACC_W-1:0] inc_i,
  input  logic [NCH-1:0]       inc_load_i,
  output logic [NCH-1:0]       clk_div_o,
  output logic [NCH-1:0]       clk_en_o,
  output logic [NCH-1:0]       rst_o,
  output logic                 ready_o
`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
  ,
  input  logic                 lock_loss_clr_i,
  output logic [7:0]           lock_loss_cnt_o
`endif
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int STAG_MAX = (NCH - 1) * RST_STAGGER;
  localparam int STAG_W   = (STAG_MAX > 0) ? $clog2(STAG_MAX + 1) : 1;
  localparam int FILT_W   = $clog2(LOCK_FILT + 1);
  localparam logic [ACC_W-1:0] INC_INIT = ACC_W'(INC_RST);

  logic                          lock_meta_q;
  logic                          lock_s_q;
  state_t                        state_q, state_d;
  logic [FILT_W-1:0]             filt_cnt_q, filt_cnt_d;
  logic [STAG_W-1:0]             stag_cnt_q, stag_cnt_d;
  logic [NCH-1:0]                rst_q, rst_d;
  logic                          ready_q, ready_d;
  logic [NCH-1:0][ACC_W-1:0]     acc_q, acc_d;
  logic [NCH-1:0][ACC_W-1:0]     inc_act_q, inc_act_d;
  logic [NCH-1:0][ACC_W-1:0]     inc_pend_q, inc_pend_d;
  logic [NCH-1:0][ACC_W:0]       sum;
  logic [NCH-1:0]                adv;
  logic [NCH-1:0]                wrap;
  logic [NCH-1:0]                div_q, div_d;
  logic [NCH-1:0]                en_q, en_d;
  logic                          lock_loss;

  assign lock_loss = (state_q == RUN) && !lock_s_q;

  // The carry-out of the accumulator add marks a period boundary.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sum[k]  = {1'b0, acc_q[k]} + {1'b0, inc_act_q[k]};
      adv[k]  = (state_q == RUN) && lock_s_q && !rst_q[k];
      wrap[k] = adv[k] && sum[k][ACC_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    stag_cnt_d = stag_cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d    = FILTER;
          filt_cnt_d = FILT_W'(1);
        end
      end
      FILTER: begin
        if (!lock_s_q) begin
          state_d    = WAIT_LOCK;
          filt_cnt_d = '0;
        end else if (int'(filt_cnt_q) + 1 >= LOCK_FILT) begin
          state_d    = RUN;
          stag_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (stag_cnt_q != STAG_W'(STAG_MAX)) begin
          stag_cnt_d = stag_cnt_q + STAG_W'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // A load lands on the next wrap unless the channel is idle, in reset or not running.
  always_comb begin
    rst_d      = rst_q;
    acc_d      = acc_q;
    inc_act_d  = inc_act_q;
    inc_pend_d = inc_pend_q;
    div_d      = '0;
    for (int k = 0; k < NCH; k++) begin
      if ((state_q == RUN) && lock_s_q && (stag_cnt_q == STAG_W'(k * RST_STAGGER))) begin
        rst_d[k] = 1'b0;
      end
      if (adv[k]) begin
        acc_d[k] = sum[k][ACC_W-1:0];
      end
      if (inc_load_i[k]) begin
        inc_pend_d[k] = inc_i[k*ACC_W +: ACC_W];
      end
      if (wrap[k]) begin
        inc_act_d[k] = inc_load_i[k] ? inc_i[k*ACC_W +: ACC_W] : inc_pend_q[k];
      end else if (inc_load_i[k] &&
                   ((inc_act_q[k] == '0) || (state_q != RUN) || rst_q[k])) begin
        inc_act_d[k] = inc_i[k*ACC_W +: ACC_W];
      end
    end
    if (lock_loss) begin
      rst_d = '1;
      acc_d = '0;
    end
    ready_d = (rst_d == '0);
    for (int k = 0; k < NCH; k++) begin
      div_d[k] = acc_d[k][ACC_W-1];
    end
    en_d = div_d & ~div_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= WAIT_LOCK;
      filt_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      rst_q       <= '1;
      ready_q     <= 1'b0;
      acc_q       <= '0;
      inc_act_q   <= {NCH{INC_INIT}};
      inc_pend_q  <= {NCH{INC_INIT}};
      div_q       <= '0;
      en_q        <= '0;
    end else begin
      lock_meta_q <= locked_i;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      filt_cnt_q  <= filt_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      rst_q       <= rst_d;
      ready_q     <= ready_d;
      acc_q       <= acc_d;
      inc_act_q   <= inc_act_d;
      inc_pend_q  <= inc_pend_d;
      div_q       <= div_d;
      en_q        <= en_d;
    end
  end

`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_loss_clr_i) begin
      loss_cnt_d = '0;
    end else if (lock_loss && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt_o = loss_cnt_q;
`endif

  assign clk_div_o = div_q;
  assign clk_en_o  = en_q;
  assign rst_o     = rst_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: a phase/lock-streak model compared every cycle,
// plus directed scenarios with hand-computed timings.

module tb_clk_div_multi;

  localparam int NCH         = 2;
  localparam int ACC_W       = 8;
  localparam int INC_RST     = 0;
  localparam int LOCK_FILT   = 4;
  localparam int RST_STAGGER = 3;
  localparam int MODV        = 1 << ACC_W;
  localparam int HALF        = 1 << (ACC_W - 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 locked_i = 1'b0;
  logic [NCH*ACC_W-1:0] inc_i = '0;
  logic [NCH-1:0]       inc_load_i = '0;
  logic [NCH-1:0]       clk_div_o;
  logic [NCH-1:0]       clk_en_o;
  logic [NCH-1:0]       rst_o;
  logic                 ready_o;
`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
  logic                 lock_loss_clr_i = 1'b0;
  logic [7:0]           lock_loss_cnt_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Model state: lock_s is locked_i delayed two edges; streak counts consecutive lock_s=1 samples.
  logic     m_s1 = 1'b0;
  logic     m_s2 = 1'b0;
  int       m_streak = 0;
  int       m_phase [NCH] = '{default: 0};
  int       m_act   [NCH] = '{default: INC_RST};
  int       m_pend  [NCH] = '{default: INC_RST};
  logic [NCH-1:0] m_div   = '0;
  logic [NCH-1:0] m_en    = '0;
  logic [NCH-1:0] m_rst   = '1;
  logic           m_ready = 1'b0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NCH        (NCH),
    .ACC_W      (ACC_W),
    .INC_RST    (INC_RST),
    .LOCK_FILT  (LOCK_FILT),
    .RST_STAGGER(RST_STAGGER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked_i  (locked_i),
    .inc_i     (inc_i),
    .inc_load_i(inc_load_i),
    .clk_div_o (clk_div_o),
    .clk_en_o  (clk_en_o),
    .rst_o     (rst_o),
    .ready_o   (ready_o)
`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_clr_i(lock_loss_clr_i),
    .lock_loss_cnt_o(lock_loss_cnt_o)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lk, input logic [1:0] ld, input logic [7:0] i0, input logic [7:0] i1);
    locked_i   = lk;
    inc_load_i = ld;
    inc_i      = {i1, i0};
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitEn(input int ch, output int t);
    int n;
    n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while ((clk_en_o[ch] !== 1'b1) && (n < 64));
    if (clk_en_o[ch] === 1'b1) begin
      t = cyc;
    end else begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL en_timeout ch%0d at cycle %0d: got no pulse, expected one within 64 cycles", ch, cyc);
    end
  endtask

  task automatic modelStep();
    logic       lock_now;
    logic       was_run;
    logic       rel;
    logic       wrapped;
    logic [7:0] slice;
    logic       d;
    int         nxt;
    if (rst) begin
      m_s1     = 1'b0;
      m_s2     = 1'b0;
      m_streak = 0;
      for (int k = 0; k < NCH; k++) begin
        m_phase[k] = 0;
        m_act[k]   = INC_RST;
        m_pend[k]  = INC_RST;
      end
      m_div = '0;
    end else begin
      lock_now = m_s2;
      was_run  = (m_streak >= LOCK_FILT);
      for (int k = 0; k < NCH; k++) begin
        slice = inc_i[k*ACC_W +: ACC_W];
        rel   = (m_streak >= LOCK_FILT + 1 + k * RST_STAGGER);
        if (was_run && !lock_now) begin
          m_phase[k] = 0;
        end else begin
          wrapped = 1'b0;
          if (rel) begin
            nxt        = m_phase[k] + m_act[k];
            wrapped    = (nxt >= MODV);
            m_phase[k] = nxt % MODV;
          end
          if (wrapped) begin
            m_act[k] = inc_load_i[k] ? int'(slice) : m_pend[k];
          end else if (inc_load_i[k] && ((m_act[k] == 0) || !was_run || !rel)) begin
            m_act[k] = int'(slice);
          end
        end
        if (inc_load_i[k]) m_pend[k] = int'(slice);
      end
      if (!lock_now) m_streak = 0;
      else if (m_streak < 1000) m_streak++;
      m_s2 = m_s1;
      m_s1 = locked_i;
    end
    for (int k = 0; k < NCH; k++) begin
      m_rst[k] = !(m_streak >= LOCK_FILT + 1 + k * RST_STAGGER);
      d        = (m_phase[k] >= HALF);
      m_en[k]  = d && !m_div[k];
      m_div[k] = d;
    end
    m_ready = (m_streak >= LOCK_FILT + 1 + (NCH - 1) * RST_STAGGER);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_div", clk_div_o, m_div);
      checkOutput("model_en", clk_en_o, m_en);
      checkOutput("model_rst", rst_o, m_rst);
      checkOutput("model_ready", ready_o, m_ready);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog at cycle %0d: got no finish, expected finish before 200us", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t_l, t_d, t_f, a, b, t;
    int exp_iv [6] = '{2, 3, 3, 2, 3, 3};

    // Reset with lock low.
    applyStimulus(1'b0, 2'b00, 8'd0, 8'd0);
    step(3);
    checkOutput("reset_rst_o", rst_o, 2'b11);
    checkOutput("reset_ready", ready_o, 1'b0);
    checkOutput("reset_div", clk_div_o, 2'b00);
    checkOutput("reset_en", clk_en_o, 2'b00);
`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
    checkOutput("reset_loss_cnt", lock_loss_cnt_o, 8'd0);
`endif
    rst = 1'b0;
    step(1);
    checkOutput("prelock_rst_o", rst_o, 2'b11);

    // Program ch0=64, ch1=96 before lock.
    applyStimulus(1'b0, 2'b11, 8'd64, 8'd96);
    step(1);
    applyStimulus(1'b0, 2'b00, 8'd64, 8'd96);
    step(2);

    // Lock rises: RUN after 6 edges, rst_o[0] falls at 7, rst_o[1] at 10.
    applyStimulus(1'b1, 2'b00, 8'd64, 8'd96);
    t_l = cyc;
    step(6);
    checkOutput("run_entry_rst_o", rst_o, 2'b11);
    step(1);
    checkOutput("rst0_release", rst_o, 2'b10);
    checkOutput("rst0_ready", ready_o, 1'b0);
    step(2);
    checkOutput("ch0_first_div", clk_div_o[0], 1'b1);
    checkOutput("ch0_first_en", clk_en_o[0], 1'b1);
    checkOutput("rst1_still_held", rst_o, 2'b10);
    step(1);
    checkOutput("rst1_release", rst_o, 2'b00);
    checkOutput("ready_rise", ready_o, 1'b1);

    // Fractional ratio on ch1.
    waitEn(1, t);
    checkOutput("ch1_first_en_cycle", t - t_l, 12);
    a = t;
    for (int i = 0; i < 6; i++) begin
      waitEn(1, b);
      checkOutput("ch1_interval", b - a, exp_iv[i]);
      a = b;
    end

    // Integer ratio on ch0.
    waitEn(0, a);
    for (int i = 0; i < 3; i++) begin
      waitEn(0, b);
      checkOutput("ch0_interval_64", b - a, 4);
      a = b;
    end

    // Mid-period reprogram to 32: old period completes, then 8-cycle periods.
    applyStimulus(1'b1, 2'b01, 8'd32, 8'd96);
    step(1);
    applyStimulus(1'b1, 2'b00, 8'd32, 8'd96);
    waitEn(0, b);
    checkOutput("reprog_transition", b - a, 6);
    a = b;
    waitEn(0, b);
    checkOutput("reprog_period_32", b - a, 8);
    a = b;

    // Load on the wrap cycle (acc=224) takes effect at that wrap.
    step(3);
    applyStimulus(1'b1, 2'b01, 8'd64, 8'd96);
    step(1);
    applyStimulus(1'b1, 2'b00, 8'd64, 8'd96);
    waitEn(0, b);
    checkOutput("bypass_transition", b - a, 6);
    a = b;
    waitEn(0, b);
    checkOutput("bypass_period_64", b - a, 4);

    // Lock glitch in RUN.
    applyStimulus(1'b0, 2'b00, 8'd64, 8'd96);
    t_d = cyc;
    step(2);
    checkOutput("glitch_before_loss", rst_o, 2'b00);
    applyStimulus(1'b1, 2'b00, 8'd64, 8'd96);
    step(1);
    checkOutput("loss_rst_o", rst_o, 2'b11);
    checkOutput("loss_ready", ready_o, 1'b0);
    checkOutput("loss_div", clk_div_o, 2'b00);
    checkOutput("loss_en", clk_en_o, 2'b00);
`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
    checkOutput("loss_cnt_1", lock_loss_cnt_o, 8'd1);
`endif
    step(5);
    checkOutput("relock_run_entry", rst_o, 2'b11);
    step(1);
    checkOutput("relock_rst0", rst_o, 2'b10);
    step(1);
    checkOutput("relock_en_early", clk_en_o, 2'b00);
    step(1);
    checkOutput("relock_ch0_en", clk_en_o, 2'b01);
    step(1);
    checkOutput("relock_rst1", rst_o, 2'b00);
    checkOutput("relock_ready", ready_o, 1'b1);
    step(2);
    checkOutput("relock_ch1_en", clk_en_o, 2'b10);
    checkOutput("relock_elapsed", cyc - t_d, 14);

    // Drop lock to return to WAIT_LOCK, then glitch during FILTER.
    applyStimulus(1'b0, 2'b00, 8'd64, 8'd96);
    step(6);
    checkOutput("unlocked_rst_o", rst_o, 2'b11);
`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
    checkOutput("loss_cnt_2", lock_loss_cnt_o, 8'd2);
`endif
    applyStimulus(1'b1, 2'b00, 8'd64, 8'd96);
    t_f = cyc;
    step(2);
    applyStimulus(1'b0, 2'b00, 8'd64, 8'd96);
    step(2);
    applyStimulus(1'b1, 2'b00, 8'd64, 8'd96);
    step(3);
    checkOutput("filter_no_early_run", rst_o, 2'b11);
    step(3);
    checkOutput("filter_run_entry", rst_o, 2'b11);
    step(1);
    checkOutput("filter_rst0", rst_o, 2'b10);
    step(3);
    checkOutput("filter_ready", ready_o, 1'b1);
    checkOutput("filter_elapsed", cyc - t_f, 14);

`ifdef CLK_DIV_LOCK_LOSS_CNT_EN
    lock_loss_clr_i = 1'b1;
    step(1);
    lock_loss_clr_i = 1'b0;
    checkOutput("loss_cnt_clear", lock_loss_cnt_o, 8'd0);
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
